// File: rtl/an_pkg.sv
// Shared constants and elaboration-time helpers for the AN-code Barrett decoders.
package an_pkg;

    localparam int unsigned AN_A    = 32'd37;
    localparam int unsigned AN_CW_W = 32'd18;
    localparam int unsigned AN_K    = 32'd19;

    // Result of one decode, as handed to the data sink.
    typedef struct packed {
        logic        err;
        logic [12:0] q;
        logic [5:0]  r;
    } an_result_t;

    // Barrett multiplier floor(2**k / a).
    function automatic longint unsigned barrett_m(input int unsigned k, input int unsigned a);
        return (64'd1 << k) / 64'(a);
    endfunction

    // Bits needed to represent values 0 .. v-1.
    function automatic int unsigned an_clog2(input longint unsigned v);
        int unsigned n;
        longint unsigned t;
        n = 32'd0;
        t = 64'd1;
        while (t < v) begin
            t = t << 1;
            n = n + 32'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/an_barrett_correct.sv
// Final Barrett correction: folds r_t in [0, 2A) back into [0, A) and flags a nonzero syndrome.
module an_barrett_correct
    import an_pkg::*;
#(
    parameter int unsigned A   = AN_A,
    parameter int unsigned Q_W = 32'd13,
    parameter int unsigned R_W = 32'd6
) (
    input  logic [Q_W-1:0] i_qt,
    input  logic [R_W:0]   i_rt,
    output logic [Q_W-1:0] o_q,
    output logic [R_W-1:0] o_r,
    output logic           o_err
);

    localparam logic [R_W:0] A_X = (R_W + 1)'(A);

    logic [R_W:0] w_sub;

    assign w_sub = i_rt - A_X;

    // Subtract A once when the estimate undershot the true quotient.
    always_comb begin
        o_q   = i_qt;
        o_r   = i_rt[R_W-1:0];
        o_err = 1'b0;
        if (i_rt >= A_X) begin
            o_q = i_qt + Q_W'(1);
            o_r = w_sub[R_W-1:0];
        end else begin
            o_q = i_qt;
            o_r = i_rt[R_W-1:0];
        end
        o_err = (o_r != {R_W{1'b0}});
    end

endmodule

// File: rtl/an_barrett_decoder_pipe.sv
// Three-stage pipelined AN-code decoder (Barrett division by A) with valid/ready flow control.
// Optional saturating error counter enabled by defining AN_ERR_CNT_EN.
module an_barrett_decoder_pipe
    import an_pkg::*;
#(
    parameter int unsigned CW_W      = AN_CW_W,
    parameter int unsigned A         = AN_A,
    parameter int unsigned K         = AN_K,
    parameter int unsigned Q_W       = 32'd13,
    parameter int unsigned R_W       = 32'd6,
    parameter int unsigned ERR_CNT_W = 32'd16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW_W-1:0] in_cw,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Q_W-1:0]  out_q,
    output logic [R_W-1:0]  out_r,
    output logic            out_err,
    output logic [CW_W-1:0] out_cw
`ifdef AN_ERR_CNT_EN
    ,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam longint unsigned M   = barrett_m(K, A);
    localparam int unsigned     P_W = CW_W + an_clog2(M + 64'd1);
    localparam logic [P_W-1:0]  M_P = P_W'(M);
    localparam logic [R_W-1:0]  A_R = R_W'(A);

    if ((A % 32'd2) == 32'd0) begin : g_chk_a_even
        $error("an_barrett_decoder_pipe: A must be odd");
    end
    if (A < 32'd3) begin : g_chk_a_small
        $error("an_barrett_decoder_pipe: A must be at least 3");
    end
    if ((64'd1 << R_W) <= 64'(A)) begin : g_chk_r_w
        $error("an_barrett_decoder_pipe: 2**R_W must exceed A");
    end
    if (K < CW_W + 32'd1) begin : g_chk_k
        $error("an_barrett_decoder_pipe: K must be at least CW_W+1");
    end

    logic                 r_s1_valid;
    logic [CW_W-1:0]      r_s1_cw;
    logic [P_W-1:0]       r_s1_p;
    logic                 r_s2_valid;
    logic [CW_W-1:0]      r_s2_cw;
    logic [Q_W-1:0]       r_s2_qt;
    logic [R_W:0]         r_s2_rt;
    logic                 r_out_valid;
    logic [Q_W-1:0]       r_out_q;
    logic [R_W-1:0]       r_out_r;
    logic                 r_out_err;
    logic [CW_W-1:0]      r_out_cw;

    logic                 w_out_free;
    logic                 w_s2_free;
    logic [P_W-1:0]       w_p;
    logic [Q_W-1:0]       w_qt;
    logic [Q_W+R_W-1:0]   w_qa;
    logic [R_W:0]         w_rt;
    logic [Q_W-1:0]       w_q;
    logic [R_W-1:0]       w_r;
    logic                 w_err;
    logic                 w_unused_bits;

    // A stage may load whenever the stage behind it is empty or draining this cycle.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_s2_free  = !r_s2_valid || w_out_free;
    assign in_ready   = !r_s1_valid || w_s2_free;

    assign w_p  = {{(P_W-CW_W){1'b0}}, in_cw} * M_P;
    assign w_qt = r_s1_p[K +: Q_W];
    assign w_qa = {{R_W{1'b0}}, w_qt} * {{Q_W{1'b0}}, A_R};
    // Only the low R_W+1 bits matter: the true difference is known to lie in [0, 2A).
    assign w_rt = r_s1_cw[R_W:0] - w_qa[R_W:0];

    assign w_unused_bits = ^{r_s1_p[K-1:0], w_qa[Q_W+R_W-1:R_W+1]};

    an_barrett_correct #(
        .A   (A),
        .Q_W (Q_W),
        .R_W (R_W)
    ) u_correct (
        .i_qt  (r_s2_qt),
        .i_rt  (r_s2_rt),
        .o_q   (w_q),
        .o_r   (w_r),
        .o_err (w_err)
    );

    // Stage 1: capture codeword and full-width Barrett product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= {CW_W{1'b0}};
            r_s1_p     <= {P_W{1'b0}};
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cw <= in_cw;
                r_s1_p  <= w_p;
            end
        end
    end

    // Stage 2: quotient estimate and uncorrected remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_cw    <= {CW_W{1'b0}};
            r_s2_qt    <= {Q_W{1'b0}};
            r_s2_rt    <= {(R_W+1){1'b0}};
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_cw <= r_s1_cw;
                r_s2_qt <= w_qt;
                r_s2_rt <= w_rt;
            end
        end
    end

    // Stage 3: corrected result register; holds steady while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_q     <= {Q_W{1'b0}};
            r_out_r     <= {R_W{1'b0}};
            r_out_err   <= 1'b0;
            r_out_cw    <= {CW_W{1'b0}};
        end else if (w_out_free) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_q   <= w_q;
                r_out_r   <= w_r;
                r_out_err <= w_err;
                r_out_cw  <= r_s2_cw;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_q     = r_out_q;
    assign out_r     = r_out_r;
    assign out_err   = r_out_err;
    assign out_cw    = r_out_cw;

`ifdef AN_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating count of erroneous results delivered; clear wins over a same-cycle error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= {ERR_CNT_W{1'b0}};
        end else if (err_clr) begin
            r_err_cnt <= {ERR_CNT_W{1'b0}};
        end else if (r_out_valid && out_ready && r_out_err &&
                     (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_an_barrett_decoder_pipe.sv
// Directed/random self-checking bench for an_barrett_decoder_pipe (A=37, 18-bit codewords).
module tb_an_barrett_decoder_pipe;

    typedef struct {
        logic [17:0] cw;
        logic [12:0] q;
        logic [5:0]  r;
        int          t;
        bit          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_cw;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_q;
    logic [5:0]  out_r;
    logic        out_err;
    logic [17:0] out_cw;
    logic        err_clr;
    logic [1:0]  err_cnt;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q_exp[$];
    bit   hold_chk = 1'b0;
    logic [12:0] h_q;
    logic [5:0]  h_r;
    logic        h_err;
    logic [17:0] h_cw;

    an_barrett_decoder_pipe #(
        .CW_W      (18),
        .A         (37),
        .K         (19),
        .Q_W       (13),
        .R_W       (6),
        .ERR_CNT_W (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_err   (out_err),
        .out_cw    (out_cw)
`ifdef AN_ERR_CNT_EN
        ,
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge, check the output side, track accepted inputs.
    task automatic tick(input bit v, input logic [17:0] cw, input bit ordy,
                        input logic [12:0] eq, input logic [5:0] er, input bit lat);
        exp_t e;
        in_valid  = v;
        in_cw     = cw;
        out_ready = ordy;
        #1;
        if (hold_chk) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_q",     32'(out_q),     32'(h_q));
            chk("stall_r",     32'(out_r),     32'(h_r));
            chk("stall_err",   32'(out_err),   32'(h_err));
            chk("stall_cw",    32'(out_cw),    32'(h_cw));
        end
        chk("in_ready", 32'(in_ready), 32'((q_exp.size() < 3) || ordy));
        if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q_exp.pop_front();
                chk("out_q",   32'(out_q),   32'(e.q));
                chk("out_r",   32'(out_r),   32'(e.r));
                chk("out_err", 32'(out_err), 32'(e.r != 6'd0));
                chk("out_cw",  32'(out_cw),  32'(e.cw));
                if (e.lat) chk("latency", 32'(cyc - e.t), 32'd3);
            end
        end
        hold_chk = out_valid && !out_ready;
        h_q = out_q; h_r = out_r; h_err = out_err; h_cw = out_cw;
        if (in_valid && in_ready) begin
            e.cw = cw; e.q = eq; e.r = er; e.t = cyc; e.lat = lat;
            q_exp.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q_exp.size() != 0; i++) tick(1'b0, 18'd0, 1'b1, 13'd0, 6'd0, 1'b0);
        chk("drain_left", 32'(q_exp.size()), 32'd0);
    endtask

    initial begin
        logic [17:0] rcw;
        rst_n = 1'b0; in_valid = 1'b0; in_cw = 18'd0; out_ready = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_q",     32'(out_q),     32'd0);
        chk("rst_out_r",     32'(out_r),     32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_out_cw",    32'(out_cw),    32'd0);
`ifdef AN_ERR_CNT_EN
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed vectors, unstalled; first one also checks latency.
        tick(1'b1, 18'd0,      1'b1, 13'd0,    6'd0,  1'b1);
        tick(1'b0, 18'd0,      1'b1, 13'd0,    6'd0,  1'b0);
        tick(1'b0, 18'd0,      1'b1, 13'd0,    6'd0,  1'b0);
        tick(1'b1, 18'd37,     1'b1, 13'd1,    6'd0,  1'b1);
        tick(1'b1, 18'd74,     1'b1, 13'd2,    6'd0,  1'b0);
        tick(1'b1, 18'd262143, 1'b1, 13'd7084, 6'd35, 1'b0);
        tick(1'b1, 18'd1110,   1'b1, 13'd30,   6'd0,  1'b0);
        tick(1'b1, 18'd38,     1'b1, 13'd1,    6'd1,  1'b0);
        drain();

        // Back-to-back random stream with random sink stalls.
        for (int i = 0; i < 20; i++) begin
            rcw = 18'($urandom_range(0, 262143));
            tick(1'b1, rcw, 1'($urandom_range(0, 1)), 13'(rcw / 18'd37), 6'(rcw % 18'd37), 1'b0);
            while (q_exp.size() != 0 && q_exp[q_exp.size()-1].cw != rcw && !in_ready)
                tick(1'b1, rcw, 1'($urandom_range(0, 1)), 13'(rcw / 18'd37), 6'(rcw % 18'd37), 1'b0);
        end
        drain();

        // Fill all three stages, prove back-pressure, then reset mid-flight.
        tick(1'b1, 18'd100, 1'b0, 13'd2, 6'd26, 1'b0);
        tick(1'b1, 18'd200, 1'b0, 13'd5, 6'd15, 1'b0);
        tick(1'b1, 18'd300, 1'b0, 13'd8, 6'd4,  1'b0);
        tick(1'b1, 18'd400, 1'b0, 13'd10, 6'd30, 1'b0);
        chk("full_depth", 32'(q_exp.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        q_exp.delete();
        hold_chk = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 18'd0, 1'b1, 13'd0, 6'd0, 1'b0);
            chk("no_stale", 32'(out_valid), 32'd0);
        end

`ifdef AN_ERR_CNT_EN
        // Counter saturation and clear priority with ERR_CNT_W=2.
        for (int i = 0; i < 5; i++) tick(1'b1, 18'd1, 1'b1, 13'd0, 6'd1, 1'b0);
        drain();
        chk("err_cnt_sat", 32'(err_cnt), 32'd3);
        tick(1'b1, 18'd2, 1'b0, 13'd0, 6'd2, 1'b0);
        for (int i = 0; i < 10 && !out_valid; i++) tick(1'b0, 18'd0, 1'b0, 13'd0, 6'd0, 1'b0);
        chk("err_pending", 32'(out_valid), 32'd1);
        err_clr = 1'b1;
        tick(1'b0, 18'd0, 1'b1, 13'd0, 6'd0, 1'b0);
        err_clr = 1'b0;
        chk("err_cnt_clr", 32'(err_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/an_barrett_decoder_pipe.md
Name: an_barrett_decoder_pipe

Overview:
- Parametrised, pipelined AN-code decoder. Divides each received codeword by the code constant A using Barrett reduction, producing quotient (decoded data), remainder (syndrome) and an error flag.
- Successor to the fixed A=37, 18-bit combinational decoder. Adds generic A and width, a 3-stage pipeline with valid/ready back-pressure, and an optional saturating error counter.
- Sits between the channel/receive buffer and the data sink.

Parameters:
- CW_W, 18, codeword width in bits.
- A, 37, AN-code constant; odd, 3 <= A < 2**R_W.
- K, 19, Barrett shift; K >= CW_W + 1.
- Q_W, 13, quotient width; must hold floor((2**CW_W-1)/A).
- R_W, 6, remainder width; 2**R_W > A.
- ERR_CNT_W, 16, error counter width (used only with the optional feature).
- Derived localparam M = floor(2**K / A); default 14169.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  codeword valid
- in_ready  out  1  block can accept a codeword
- in_cw  in  CW_W  received codeword
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_q  out  Q_W  quotient
- out_r  out  R_W  remainder (syndrome)
- out_err  out  1  1 when out_r != 0
- out_cw  out  CW_W  codeword passed through, aligned with its result
- err_clr  in  1  synchronous clear of err_cnt (optional feature only)
- err_cnt  out  ERR_CNT_W  saturating error count (optional feature only)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). All stage valids clear; out_valid, out_q, out_r, out_err, out_cw and err_cnt reset to 0; in_ready = 1 once reset is released.
- S1: register cw and the product P = cw*M. P is CW_W+clog2(M+1) bits; no truncation.
- S2: q_t = P >> K and r_t = cw - q_t*A. r_t is computed R_W+1 bits wide; the design guarantees 0 <= r_t < 2A.
- S3 (output register):
  - If r_t >= A: q = q_t+1 and r = r_t-A.
  - Otherwise: q = q_t and r = r_t.
  - err = (r != 0). cw passes through unchanged.
- Latency: 3 cycles from input handshake to out_valid when unstalled. Throughput: 1 result per cycle.
- Handshake:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Stage n advances when stage n+1 is empty or advancing.
  - in_ready = !s1_valid || s1_advance. It is combinational from out_ready; no combinational path from in_valid to out_valid.
  - While out_valid && !out_ready, every out_* output holds stable and the pipeline fills without losing any entry. At most 3 entries are held.
  - Simultaneous in and out transfer with a full pipeline is legal and lossless.
- Bubbles: empty stages carry valid=0 only; data registers in empty stages need not be reset.
- Reset asserted mid-operation drops all in-flight entries immediately.
- Elaboration: $error if A is even, A < 3, 2**R_W <= A, or K < CW_W+1.

Optional Feature:
- Macro AN_ERR_CNT_EN.
- When defined:
  - err_clr and err_cnt ports exist.
  - err_cnt increments on each output transfer with out_err = 1 and saturates at all-ones.
  - err_clr has priority and forces 0 next cycle. An error transfer in the same cycle as err_clr is not counted.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Package an_pkg:
  - function barrett_m(K, A) returning floor(2**K/A).
  - clog2 helper.
  - Default constants AN_A=37, AN_CW_W=18, AN_K=19.
- Sub-module an_barrett_correct: the combinational S3 correction stage (q_t, r_t -> q, r, err), parametrised by A, Q_W and R_W. It is reusable by the combinational decoder.

Test Plan:
- Reset, then in_cw=0 with out_ready=1 -> 3 cycles later out_q=0, out_r=0, out_err=0, out_cw=0.
- in_cw=37 -> q_t=0, r_t=37 corrected to out_q=1, out_r=0, out_err=0. in_cw=74 -> out_q=2, out_r=0 (correction path).
- in_cw=262143 -> out_q=7084, out_r=35, out_err=1. in_cw=1110 -> out_q=30, out_r=0, out_err=0.
- Back-to-back stream of 20 random codewords with out_ready toggled at random -> results match a golden div/mod model in order, with no loss or duplication, and out_* stable while stalled. in_ready falls only when 3 entries are held.
- Assert rst_n low for 1 cycle with 3 entries in flight -> out_valid=0 asynchronously; after release, no stale result appears.
- With AN_ERR_CNT_EN and ERR_CNT_W=2: 5 erroneous codewords -> err_cnt=3 (saturated). err_clr pulsed alongside an error transfer -> err_cnt=0.
